// File: rtl/osd_stm_trace_frontend.sv
// osd_stm_trace_frontend
// Software-trace front end between a core retirement trace port and the STM.
// It detects marker instructions and pairs each with a shadow copy of a value
// register. Writebacks to that register in the same cycle are bypassed in.
// Events go into a first-word-fall-through FIFO with a valid/ready output.
// Events lost to a full FIFO are counted and reported in-band as overflow
// records, which carry id 0 and the drop count as the value.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   enable          capture enable (the shadow register is always updated)
//   trace_valid     instruction retired this cycle
//   trace_insn      retired instruction word
//   trace_wben      writeback valid
//   trace_wbreg     writeback register index
//   trace_wbdata    writeback data
//   out_valid       event available at FIFO head
//   out_ready       consumer accepts head event
//   out_id          event id (0 = overflow record)
//   out_value       event value or zero-extended drop count
//   drop_count      live drop counter
module osd_stm_trace_frontend #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned VALUE_REG      = 3,
  parameter logic [15:0] MARKER         = 16'h1500,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      trace_valid,
  input  logic [31:0]               trace_insn,
  input  logic                      trace_wben,
  input  logic [REG_ADDR_WIDTH-1:0] trace_wbreg,
  input  logic [XLEN-1:0]           trace_wbdata,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [15:0]               out_id,
  output logic [XLEN-1:0]           out_value,
  output logic [CNT_WIDTH-1:0]      drop_count
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0]             DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [REG_ADDR_WIDTH-1:0] VREG    = REG_ADDR_WIDTH'(VALUE_REG);

  logic [XLEN-1:0] shadow;
  logic [15:0]     mem_id  [FIFO_DEPTH];
  logic [XLEN-1:0] mem_val [FIFO_DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;

  logic            wb_hit, evt, pop, slot_free, push;
  logic [15:0]     push_id;
  logic [XLEN-1:0] push_val, evt_val;

  assign wb_hit  = trace_wben && (trace_wbreg == VREG);
  assign evt     = trace_valid && enable && (trace_insn[31:16] == MARKER) &&
                   (trace_insn[15:0] != '0);
  assign evt_val = wb_hit ? trace_wbdata : shadow;

  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign slot_free = (count < DEPTH_C) || pop;

  // Head outputs are forced to zero while empty so stale entries never leak.
  assign out_id    = out_valid ? mem_id[rd_ptr]  : '0;
  assign out_value = out_valid ? mem_val[rd_ptr] : '0;

  // A pending overflow record takes the single push slot ahead of a new event,
  // which keeps the record in stream order with the events it stands for.
  always_comb begin
    push     = 1'b0;
    push_id  = '0;
    push_val = '0;
    if (slot_free) begin
      if (drop_count != '0) begin
        push     = 1'b1;
        push_val = XLEN'(drop_count);
      end else if (evt) begin
        push     = 1'b1;
        push_id  = trace_insn[15:0];
        push_val = evt_val;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow     <= '0;
      drop_count <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_id[i]  <= '0;
        mem_val[i] <= '0;
      end
    end else begin
      if (wb_hit) shadow <= trace_wbdata;

      if (slot_free && (drop_count != '0))
        drop_count <= evt ? CNT_WIDTH'(1) : '0;
      else if (evt && !slot_free && (drop_count != '1))
        drop_count <= drop_count + 1'b1;

      if (push) begin
        mem_id[wr_ptr]  <= push_id;
        mem_val[wr_ptr] <= push_val;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_osd_stm_trace_frontend.sv
module tb_osd_stm_trace_frontend;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        trace_valid;
  logic [31:0] trace_insn;
  logic        trace_wben;
  logic [4:0]  trace_wbreg;
  logic [31:0] trace_wbdata;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_id;
  logic [31:0] out_value;
  logic [15:0] drop_count;

  osd_stm_trace_frontend #(
    .XLEN(32), .REG_ADDR_WIDTH(5), .VALUE_REG(3), .MARKER(16'h1500),
    .FIFO_DEPTH(DEPTH), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .trace_valid(trace_valid),
    .trace_insn(trace_insn), .trace_wben(trace_wben), .trace_wbreg(trace_wbreg),
    .trace_wbdata(trace_wbdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_id(out_id), .out_value(out_value), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: an ordered list of pending records plus a drop tally.
  int unsigned   m_id[$];
  int unsigned   m_val[$];
  int unsigned   m_drop;
  int unsigned   m_shadow;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_id.delete();
    m_val.delete();
    m_drop   = 0;
    m_shadow = 0;
  endtask

  task automatic model_check();
    chk("out_valid", {63'b0, out_valid}, {63'b0, m_id.size() != 0});
    chk("drop_count", {48'b0, drop_count}, 64'(m_drop));
    if (m_id.size() != 0) begin
      chk("out_id", {48'b0, out_id}, 64'(m_id[0]));
      chk("out_value", {32'b0, out_value}, 64'(m_val[0]));
    end
  endtask

  // One clock: drive inputs, compare against model, advance the model.
  task automatic step(input logic v, input logic [31:0] insn, input logic wb,
                      input logic [4:0] reg_i, input logic [31:0] data,
                      input logic rdy, input logic en);
    bit          hit, ev, pp, free;
    int unsigned val;
    trace_valid = v; trace_insn = insn; trace_wben = wb; trace_wbreg = reg_i;
    trace_wbdata = data; out_ready = rdy; enable = en;
    #1;
    model_check();
    hit  = wb && (reg_i == 5'd3);
    ev   = v && en && (insn[31:16] == 16'h1500) && (insn[15:0] != 16'h0);
    val  = hit ? data : m_shadow;
    pp   = (m_id.size() != 0) && rdy;
    free = (m_id.size() < DEPTH) || pp;
    @(posedge clk);
    if (pp) begin void'(m_id.pop_front()); void'(m_val.pop_front()); end
    if (m_drop != 0 && free) begin
      m_id.push_back(0); m_val.push_back(m_drop);
      m_drop = ev ? 1 : 0;
    end else if (ev && free) begin
      m_id.push_back(insn[15:0]); m_val.push_back(val);
    end else if (ev && m_drop < 32'hFFFF) begin
      m_drop++;
    end
    if (hit) m_shadow = data;
    @(negedge clk);
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, rdy, 1'b1);
  endtask

  task automatic marker(input logic [15:0] id, input logic rdy);
    step(1'b1, {16'h1500, id}, 1'b0, 5'd0, 32'h0, rdy, 1'b1);
  endtask

  initial begin
    logic [15:0] exp_ids [5];
    rst = 1'b1; enable = 1'b1; trace_valid = 1'b0; trace_insn = '0;
    trace_wben = 1'b0; trace_wbreg = '0; trace_wbdata = '0; out_ready = 1'b0;
    model_reset();
    #12;
    chk("reset out_valid", {63'b0, out_valid}, 64'd0);
    chk("reset out_id", {48'b0, out_id}, 64'd0);
    chk("reset out_value", {32'b0, out_value}, 64'd0);
    chk("reset drop_count", {48'b0, drop_count}, 64'd0);
    @(negedge clk); rst = 1'b0;

    // Shadow capture then marker
    step(1'b0, 32'h0, 1'b1, 5'd3, 32'hDEAD_BEEF, 1'b1, 1'b1);
    idle(1'b1);
    step(1'b1, 32'h1500_0042, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1);
    chk("t1 valid", {63'b0, out_valid}, 64'd1);
    chk("t1 id", {48'b0, out_id}, 64'h42);
    chk("t1 value", {32'b0, out_value}, 64'hDEAD_BEEF);
    idle(1'b1);
    chk("t1 single", {63'b0, out_valid}, 64'd0);

    // Non-events
    step(1'b1, 32'h1500_0000, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1);
    step(1'b1, 32'h1501_0007, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1);
    step(1'b1, 32'h1500_0009, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    chk("t2 none", {63'b0, out_valid}, 64'd0);
    chk("t2 drops", {48'b0, drop_count}, 64'd0);

    // Bypass
    step(1'b0, 32'h0, 1'b1, 5'd3, 32'h0, 1'b1, 1'b1);
    step(1'b1, 32'h1500_0005, 1'b1, 5'd3, 32'h1234_5678, 1'b1, 1'b1);
    chk("t3 id", {48'b0, out_id}, 64'h5);
    chk("t3 bypass", {32'b0, out_value}, 64'h1234_5678);
    idle(1'b1);

    // Overflow
    for (int i = 1; i <= 6; i++) marker(16'(i), 1'b0);
    chk("t4 drops", {48'b0, drop_count}, 64'd2);
    exp_ids = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd0};
    for (int i = 0; i < 5; i++) begin
      chk("t4 order", {48'b0, out_id}, 64'(exp_ids[i]));
      if (i == 4) chk("t4 ovf value", {32'b0, out_value}, 64'd2);
      idle(1'b1);
    end
    chk("t4 drops clear", {48'b0, drop_count}, 64'd0);
    chk("t4 empty", {63'b0, out_valid}, 64'd0);

    // Push and pop together at full
    for (int i = 0; i < 4; i++) marker(16'(10 + i), 1'b0);
    for (int i = 0; i < 6; i++) begin
      chk("t5 head", {48'b0, out_id}, 64'(10 + i));
      marker(16'(14 + i), 1'b1);
    end
    chk("t5 drops", {48'b0, drop_count}, 64'd0);
    for (int i = 0; i < 4; i++) idle(1'b1);

    // Mid-stream reset
    for (int i = 0; i < 5; i++) marker(16'(20 + i), 1'b0);
    chk("t6 pre drops", {48'b0, drop_count}, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6 rst valid", {63'b0, out_valid}, 64'd0);
    chk("t6 rst drops", {48'b0, drop_count}, 64'd0);
    model_reset();
    @(negedge clk); rst = 1'b0;
    marker(16'h0077, 1'b1);
    chk("t6 id", {48'b0, out_id}, 64'h77);
    chk("t6 value", {32'b0, out_value}, 64'h0);
    idle(1'b1);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [31:0] insn;
      insn = $urandom;
      if ($urandom_range(0, 1) == 1) insn = {16'h1500, 14'h0, 2'($urandom_range(0, 3))};
      step(1'($urandom_range(0, 3) != 0), insn, 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 9) != 0));
    end
    for (int n = 0; n < 12; n++) idle(1'b1);
    model_check();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
